// File: rtl/lcd_value_display_if.sv
// Value handshake between an arithmetic source and the LCD value writer.
// The source drives val/val_valid; the writer reports val_ready and busy.
interface lcd_value_display_if #(
  parameter int unsigned VAL_W = 8
) ();
  logic [VAL_W-1:0] val;
  logic             val_valid;
  logic             val_ready;
  logic             busy;

  modport master (
    output val,
    output val_valid,
    input  val_ready,
    input  busy
  );

  modport slave (
    input  val,
    input  val_valid,
    output val_ready,
    output busy
  );
endinterface

// File: rtl/lcd_value_display.sv
// HD44780 8-bit writer: init sequence, fixed "Result =" label on line 1 and an unsigned
// value as zero-padded decimal on line 2, converted sequentially by double dabble.
module lcd_value_display #(
  parameter int unsigned VAL_W    = 8,
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned STEP_CYC = 50000,
  parameter int unsigned CLR_CYC  = 100000,
  parameter int unsigned PWR_CYC  = 1000000
) (
  input  logic               in_Clk,
  input  logic               in_Rst_n,
  lcd_value_display_if.slave vbus,
  output logic               lcd_rs,
  output logic               lcd_e,
  output logic [7:0]         data
);

  // Decimal digits needed to hold 2^VAL_W - 1.
  function automatic int unsigned calc_nb(input int unsigned w);
    int unsigned m;
    int unsigned n;
    m = (32'd1 << w) - 32'd1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (m != 0) begin
        m = m / 10;
        n = n + 1;
      end
    end
    return n;
  endfunction

  localparam int unsigned NB    = calc_nb(VAL_W);
  localparam int unsigned BW    = 4 * NB;
  localparam int unsigned SW    = (STEP_CYC > 2) ? $clog2(STEP_CYC) : 1;
  localparam int unsigned OvfSh = 4 * DIGITS;

  localparam logic [SW-1:0] SLast    = SW'(STEP_CYC - 1);
  localparam logic [SW-1:0] SHalf    = SW'(STEP_CYC / 2);
  localparam logic [31:0]   PwrLast  = (PWR_CYC > 0) ? 32'(PWR_CYC - 1) : 32'd0;
  localparam logic [31:0]   ClrLast  = (CLR_CYC > 0) ? 32'(CLR_CYC - 1) : 32'd0;
  localparam logic [31:0]   ConvLast = 32'(VAL_W - 1);
  localparam logic [3:0]    L1Last   = 4'd8;
  localparam logic [3:0]    L2Last   = 4'(DIGITS);
  localparam logic [63:0]   Label    = "Result =";

  typedef enum logic [2:0] {
    StPwr, StInit, StClrw, StLine1, StConv, StLine2, StIdle
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      wcnt_q, wcnt_d;
  logic [SW-1:0]    s_q, s_d;
  logic [3:0]       idx_q, idx_d;
  logic [VAL_W-1:0] cap_q, cap_d;
  logic [VAL_W-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d;
  logic             rs_q, rs_d;
  logic             e_q, e_d;
  logic [7:0]       data_q, data_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic                  slot_last;
  logic                  is_slot;
  logic [BW+VAL_W-1:0]   dd;
  logic [23:0]           bcd_ext;
  logic                  ovf;
  logic [2:0]            pos;
  logic [3:0]            digit;
  logic [8:0]            ch;

  // One double-dabble step: add 3 to every digit >= 5, then shift {bcd, bin} left.
  function automatic logic [BW+VAL_W-1:0] dabble(input logic [BW-1:0]    b,
                                                 input logic [VAL_W-1:0] v);
    logic [BW-1:0] t;
    t = b;
    for (int i = 0; i < int'(NB); i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    return {t, v} << 1;
  endfunction

  assign slot_last = (s_q == SLast);

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    s_d     = s_q;
    idx_d   = idx_q;
    cap_d   = cap_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    dd      = dabble(bcd_q, bin_q);
    case (state_q)
      StPwr: begin
        if (wcnt_q >= PwrLast) begin
          state_d = StInit;
          wcnt_d  = '0;
          s_d     = '0;
          idx_d   = '0;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      StInit, StLine1, StLine2: begin
        if (!slot_last) begin
          s_d = s_q + 1'b1;
        end else begin
          s_d   = '0;
          idx_d = idx_q + 4'd1;
          if (state_q == StInit && idx_q == 4'd3) begin
            idx_d   = '0;
            wcnt_d  = '0;
            state_d = (CLR_CYC == 0) ? StLine1 : StClrw;
          end else if (state_q == StLine1 && idx_q == L1Last) begin
            state_d = StConv;
            wcnt_d  = '0;
            bin_d   = cap_q;
            bcd_d   = '0;
          end else if (state_q == StLine2 && idx_q == L2Last) begin
            state_d = StIdle;
          end
        end
      end
      StClrw: begin
        if (wcnt_q >= ClrLast) begin
          state_d = StLine1;
          s_d     = '0;
          idx_d   = '0;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      StConv: begin
        {bcd_d, bin_d} = dd;
        if (wcnt_q >= ConvLast) begin
          state_d = StLine2;
          s_d     = '0;
          idx_d   = '0;
        end else begin
          wcnt_d = wcnt_q + 32'd1;
        end
      end
      StIdle: begin
        if (vbus.val_valid) begin
          cap_d   = vbus.val;
          bin_d   = vbus.val;
          bcd_d   = '0;
          wcnt_d  = '0;
          state_d = StConv;
        end
      end
      default: state_d = StPwr;
    endcase
  end

  // Character for the slot about to be (or being) driven; bcd_q is final during LINE2.
  always_comb begin
    bcd_ext = 24'(bcd_q);
    ovf     = (bcd_ext >> OvfSh) != 24'd0;
    pos     = 3'(DIGITS) - idx_d[2:0];
    digit   = 4'(bcd_ext >> {pos, 2'b00});
    ch      = 9'h000;
    case (state_d)
      StInit: begin
        case (idx_d[1:0])
          2'd0:    ch = 9'h038;
          2'd1:    ch = 9'h00C;
          2'd2:    ch = 9'h006;
          default: ch = 9'h001;
        endcase
      end
      StLine1: ch = (idx_d == 4'd0) ? 9'h080 : {1'b1, 8'(Label >> {4'd8 - idx_d, 3'b000})};
      StLine2: ch = (idx_d == 4'd0) ? 9'h0C0 : {1'b1, (ovf ? 8'h23 : (8'h30 + {4'h0, digit}))};
      default: ch = 9'h000;
    endcase
  end

  always_comb begin
    is_slot = (state_d == StInit) || (state_d == StLine1) || (state_d == StLine2);
    rs_d    = rs_q;
    data_d  = data_q;
    if (is_slot && s_d == '0) begin
      rs_d   = ch[8];
      data_d = ch[7:0];
    end
    e_d     = is_slot && (s_d != '0) && (s_d <= SHalf);
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge in_Clk or negedge in_Rst_n) begin
    if (!in_Rst_n) begin
      state_q <= StPwr;
      wcnt_q  <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      cap_q   <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      rs_q    <= 1'b0;
      e_q     <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      s_q     <= s_d;
      idx_q   <= idx_d;
      cap_q   <= cap_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      rs_q    <= rs_d;
      e_q     <= e_d;
      data_q  <= data_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign lcd_rs         = rs_q;
  assign lcd_e          = e_q;
  assign data           = data_q;
  assign vbus.val_ready = ready_q;
  assign vbus.busy      = busy_q;

endmodule

// File: tb/tb_lcd_value_display.sv
// Bench for lcd_value_display: two instances (3 and 2 digits) driven with random values,
// every LCD slot captured and compared against a decimal-formatting reference model.
module tb_lcd_value_display;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned STEP  = 4;
  localparam int unsigned CLR   = 8;
  localparam int unsigned PWR   = 16;

  logic in_Clk   = 1'b0;
  logic in_Rst_n = 1'b0;
  int   cyc      = 0;

  always #5 in_Clk = ~in_Clk;
  always @(posedge in_Clk) cyc <= cyc + 1;

  logic [7:0] val_drv   [2];
  logic       valid_drv [2];
  logic       ready_w   [2];
  logic       busy_w    [2];
  logic       e_w       [2];
  logic       rs_w      [2];
  logic [7:0] data_w    [2];

  lcd_value_display_if #(.VAL_W(VAL_W)) bus3 ();
  lcd_value_display_if #(.VAL_W(VAL_W)) bus2 ();

  assign bus3.val       = val_drv[0];
  assign bus3.val_valid = valid_drv[0];
  assign ready_w[0]     = bus3.val_ready;
  assign busy_w[0]      = bus3.busy;
  assign bus2.val       = val_drv[1];
  assign bus2.val_valid = valid_drv[1];
  assign ready_w[1]     = bus2.val_ready;
  assign busy_w[1]      = bus2.busy;

  lcd_value_display #(
    .VAL_W(VAL_W), .DIGITS(3), .STEP_CYC(STEP), .CLR_CYC(CLR), .PWR_CYC(PWR)
  ) dut3 (
    .in_Clk  (in_Clk),
    .in_Rst_n(in_Rst_n),
    .vbus    (bus3),
    .lcd_rs  (rs_w[0]),
    .lcd_e   (e_w[0]),
    .data    (data_w[0])
  );

  lcd_value_display #(
    .VAL_W(VAL_W), .DIGITS(2), .STEP_CYC(STEP), .CLR_CYC(CLR), .PWR_CYC(PWR)
  ) dut2 (
    .in_Clk  (in_Clk),
    .in_Rst_n(in_Rst_n),
    .vbus    (bus2),
    .lcd_rs  (rs_w[1]),
    .lcd_e   (e_w[1]),
    .data    (data_w[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: decimal text of v in d digits, or all '#' when it does not fit.
  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [8:0] model_char(input int v, input int d, input int p);
    if (v >= p10(d)) return {1'b1, 8'h23};
    return {1'b1, 8'(48 + (v / p10(d - 1 - p)) % 10)};
  endfunction

  function automatic int digs(input int k);
    return (k == 0) ? 3 : 2;
  endfunction

  logic [8:0] boot_hdr [13] = '{9'h038, 9'h00C, 9'h006, 9'h001, 9'h080,
                                9'h152, 9'h165, 9'h173, 9'h175, 9'h16C, 9'h174, 9'h120, 9'h13D};

  // Slot monitor: one entry per lcd_e rising edge, with the cycle it was seen.
  logic [8:0] q0 [$];
  logic [8:0] q1 [$];
  int         t0 [$];
  int         t1 [$];
  logic       prev_e   [2];
  logic [8:0] prev_bus [2];
  logic [8:0] slot_bus [2];
  int         run      [2];
  int         xfers    [2];

  always @(negedge in_Clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [8:0] bus;
      bus = {rs_w[k], data_w[k]};
      if (!in_Rst_n) begin
        prev_e[k] = 1'b0;
        run[k]    = 0;
      end else begin
        if (ready_w[k] && valid_drv[k]) xfers[k]++;
        if (e_w[k] && !prev_e[k]) begin
          check($sformatf("e_setup%0d", k), bus, prev_bus[k]);
          slot_bus[k] = bus;
          run[k]      = 1;
          if (k == 0) begin q0.push_back(bus); t0.push_back(cyc); end
          else        begin q1.push_back(bus); t1.push_back(cyc); end
        end else if (e_w[k]) begin
          check($sformatf("e_hold%0d", k), bus, slot_bus[k]);
          run[k]++;
        end else if (prev_e[k]) begin
          check($sformatf("e_width%0d", k), run[k], STEP / 2);
          check($sformatf("e_tail%0d", k), bus, slot_bus[k]);
        end
        prev_e[k] = e_w[k];
      end
      prev_bus[k] = bus;
    end
  end

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic logic [8:0] qget(input int k, input int i);
    if (k == 0) return (i < q0.size()) ? q0[i] : 9'h1FF;
    return (i < q1.size()) ? q1[i] : 9'h1FF;
  endfunction

  function automatic int tget(input int k, input int i);
    if (k == 0) return (i < t0.size()) ? t0[i] : -1;
    return (i < t1.size()) ? t1[i] : -1;
  endfunction

  task automatic wait_ready(input int k, input int budget, output int at);
    int n = 0;
    do begin
      @(negedge in_Clk);
      n++;
    end while (!ready_w[k] && n < budget);
    at = cyc;
    check($sformatf("ready_wait%0d", k), ready_w[k], 1);
  endtask

  task automatic send(input int k, input logic [7:0] v, input bit hold, output int tc);
    int n = 0;
    @(posedge in_Clk);
    #1;
    val_drv[k]   = v;
    valid_drv[k] = 1'b1;
    do begin
      @(negedge in_Clk);
      n++;
    end while (!ready_w[k] && n < 4000);
    check($sformatf("send_ready%0d", k), ready_w[k], 1);
    @(posedge in_Clk);
    #1;
    tc = cyc;
    if (!hold) begin
      valid_drv[k] = 1'b0;
      val_drv[k]   = 8'($urandom);
    end
  endtask

  task automatic expect_line2(input int k, input int v, input int b);
    int d = digs(k);
    check($sformatf("l2_cmd%0d", k), qget(k, b), 9'h0C0);
    for (int p = 0; p < d; p++)
      check($sformatf("l2_char%0d_%0d_v%0d", k, p, v), qget(k, b + 1 + p), model_char(v, d, p));
  endtask

  task automatic check_boot(input int k, input int b);
    int at;
    wait_ready(k, 3000, at);
    check($sformatf("boot_len%0d", k), qsize(k) - b, 14 + digs(k));
    for (int i = 0; i < 13; i++)
      check($sformatf("boot_slot%0d_%0d", k, i), qget(k, b + i), boot_hdr[i]);
    expect_line2(k, 0, b + 13);
    check($sformatf("clr_gap%0d", k),
          32'((tget(k, b + 4) - tget(k, b + 3)) >= int'(STEP + CLR)), 1);
    check($sformatf("boot_busy%0d", k), busy_w[k], 0);
  endtask

  task automatic run_value(input int k, input logic [7:0] v);
    int tc, at, b, d;
    d = digs(k);
    b = qsize(k);
    send(k, v, 1'b0, tc);
    wait_ready(k, 500, at);
    check($sformatf("idle_lat%0d", k), at, tc + VAL_W + (d + 1) * STEP);
    check($sformatf("first_rise%0d", k), tget(k, b), tc + VAL_W + 1);
    check($sformatf("l2_len%0d", k), qsize(k) - b, d + 1);
    expect_line2(k, int'(v), b);
    check($sformatf("idle_busy%0d", k), busy_w[k], 0);
  endtask

  task automatic run_hold();
    int tc, at, b, x;
    logic [7:0] v1, v2;
    v1 = 8'($urandom);
    v2 = v1 ^ 8'h5A;
    b  = qsize(0);
    x  = xfers[0];
    send(0, v1, 1'b1, tc);
    val_drv[0] = v2;
    wait_ready(0, 500, at);
    @(posedge in_Clk);
    #1;
    valid_drv[0] = 1'b0;
    val_drv[0]   = 8'($urandom);
    wait_ready(0, 500, at);
    check("xfer_count", xfers[0] - x, 2);
    check("hold_len", qsize(0) - b, 8);
    expect_line2(0, int'(v1), b);
    expect_line2(0, int'(v2), b + 4);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int tc, n, b0, b1;
    for (int k = 0; k < 2; k++) begin
      val_drv[k]   = 8'h00;
      valid_drv[k] = 1'b0;
    end
    repeat (3) @(negedge in_Clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("rst_e%0d", k), e_w[k], 0);
      check($sformatf("rst_rs%0d", k), rs_w[k], 0);
      check($sformatf("rst_data%0d", k), data_w[k], 0);
      check($sformatf("rst_ready%0d", k), ready_w[k], 0);
      check($sformatf("rst_busy%0d", k), busy_w[k], 1);
    end
    in_Rst_n = 1'b1;

    fork
      begin
        check_boot(0, 0);
        run_value(0, 8'd225);
        repeat (5) run_value(0, 8'($urandom));
        run_hold();
      end
      begin
        check_boot(1, 0);
        run_value(1, 8'd255);
        run_value(1, 8'd99);
        run_value(1, 8'd100);
        repeat (3) run_value(1, 8'($urandom));
      end
    join

    // Asynchronous reset while lcd_e is high, then a full restart.
    send(0, 8'($urandom), 1'b0, tc);
    n = 0;
    while (!e_w[0] && n < 200) begin
      @(negedge in_Clk);
      n++;
    end
    check("e_before_rst", e_w[0], 1);
    #2;
    in_Rst_n = 1'b0;
    #1;
    check("arst_e", e_w[0], 0);
    check("arst_busy", busy_w[0], 1);
    check("arst_ready", ready_w[0], 0);
    check("arst_data", data_w[0], 0);
    check("arst_e2", e_w[1], 0);
    repeat (2) @(negedge in_Clk);
    b0 = qsize(0);
    b1 = qsize(1);
    in_Rst_n = 1'b1;
    fork
      check_boot(0, b0);
      check_boot(1, b1);
    join

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
